sipo_spi_rx: RTL and testbench

Serial-in/parallel-out SPI byte receiver for the CW305 ML target. It is the receive counterpart of the target's parallel-in/serial-out transmit register. It oversamples the host's SPI lines (sclk, mosi, cs_L) in the fabric clock domain and shifts mosi in MSB-first on sclk rising edges (SPI mode 0). Each completed word is presented on a valid/ready handshake toward the ML core's input buffer, with overrun and framing-error reporting.

---
 rtl/sipo_spi_rx.sv | 152 +++++++++++++++
 tb/tb_sipo_spi_rx.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_spi_rx.sv
// SPI mode-0 serial-in/parallel-out word receiver, oversampled in the clk domain.
// Completed words are offered on a valid/ready handshake with overrun and framing-error flags.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | synchronized cs_L high; bit count and shift register held at 0
//   ST_SHIFT | frame open; mosi shifted in MSB-first on each detected sclk rise
module sipo_spi_rx #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_L,
    input  logic              sclk,
    input  logic              mosi,
    input  logic              cs_L,
    output logic [DATA_W-1:0] po,
    output logic              po_valid,
    input  logic              po_ready,
    output logic              overrun,
    input  logic              clr_ovr,
    output logic              frame_err,
    output logic              busy
);

    localparam int                CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_W - 1);

    typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic                   r_sclk_d;
    logic [DATA_W-1:0]      r_shift;
    logic [CNT_W-1:0]       r_count;
    logic [DATA_W-1:0]      r_po;
    logic                   r_po_valid;
    logic                   r_overrun;
    logic                   r_frame_err;

    logic                   w_sclk_s;
    logic                   w_mosi_s;
    logic                   w_cs_s;
    logic                   w_rise;
    logic                   w_shift_en;
    logic                   w_abort;
    logic                   w_word_done;
    logic [DATA_W-1:0]      w_word;

    // cs_L synchronizer resets high so the block comes out of reset deselected.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_cs_sync   <= '1;
            r_sclk_d    <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_L};
            r_sclk_d    <= w_sclk_s;
        end
    end

    assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];
    assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];
    assign w_rise   = w_sclk_s & ~r_sclk_d;

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (!w_cs_s) w_state_nxt = ST_SHIFT;
            ST_SHIFT: if (w_cs_s)  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_shift_en = 1'b0;
        w_abort    = 1'b0;
        case (r_state)
            ST_SHIFT: begin
                w_shift_en = ~w_cs_s & w_rise;
                w_abort    = w_cs_s;
            end
            default: ;
        endcase
    end

    assign w_word_done = w_shift_en & (r_count == LAST);
    assign w_word      = {r_shift[DATA_W-2:0], w_mosi_s};

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            r_shift     <= '0;
            r_count     <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_abort & (r_count != '0);
            if (w_abort || (r_state == ST_IDLE)) begin
                r_shift <= '0;
                r_count <= '0;
            end else if (w_shift_en) begin
                r_shift <= w_word;
                r_count <= w_word_done ? '0 : r_count + 1'b1;
            end
        end
    end

    // A word landing while the old one is being accepted replaces it without loss.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            r_po       <= '0;
            r_po_valid <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            if (w_word_done) begin
                if (!r_po_valid || po_ready) begin
                    r_po       <= w_word;
                    r_po_valid <= 1'b1;
                end
            end else if (r_po_valid && po_ready) begin
                r_po_valid <= 1'b0;
            end

            if (w_word_done && r_po_valid && !po_ready) begin
                r_overrun <= 1'b1;
            end else if (clr_ovr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign po        = r_po;
    assign po_valid  = r_po_valid;
    assign overrun   = r_overrun;
    assign frame_err = r_frame_err;
    assign busy      = ~w_cs_s;

endmodule

// File: tb/tb_sipo_spi_rx.sv
// Directed/randomized bench for sipo_spi_rx: bit-bangs SPI mode 0 and compares accepted
// words and status flags against expectations derived from the delivery rules.
module tb_sipo_spi_rx;

    localparam int DATA_W = 8;

    logic              clk;
    logic              rst_L;
    logic              sclk;
    logic              mosi;
    logic              cs_L;
    logic [DATA_W-1:0] po;
    logic              po_valid;
    logic              po_ready;
    logic              overrun;
    logic              clr_ovr;
    logic              frame_err;
    logic              busy;

    sipo_spi_rx #(.DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst_L     (rst_L),
        .sclk      (sclk),
        .mosi      (mosi),
        .cs_L      (cs_L),
        .po        (po),
        .po_valid  (po_valid),
        .po_ready  (po_ready),
        .overrun   (overrun),
        .clr_ovr   (clr_ovr),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Words the consumer actually took, plus cycle counters, sampled mid-cycle.
    logic [DATA_W-1:0] acc_q[$];
    logic [DATA_W-1:0] exp_q[$];
    int                vcyc  = 0;
    int                fecyc = 0;
    int                chk_idx = 0;

    always @(negedge clk) begin
        if (po_valid === 1'b1 && po_ready === 1'b1) acc_q.push_back(po);
        if (po_valid === 1'b1) vcyc++;
        if (frame_err === 1'b1) fecyc++;
    end

    // Snapshot taken right after the edge that completes the last bit of a send.
    logic [DATA_W-1:0] snap_po;
    logic              snap_pv;
    logic              snap_ovr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clk_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // act: 0 none, 1 assert clr_ovr on the completion edge, 2 assert po_ready on it.
    task automatic send_bit(input logic v, input int act);
        mosi = v;
        clk_wait(4);
        sclk = 1'b1;
        clk_wait(2);
        if (act == 1) clr_ovr = 1'b1;
        if (act == 2) po_ready = 1'b1;
        clk_wait(1);
        if (act != 0) begin
            snap_po  = po;
            snap_pv  = po_valid;
            snap_ovr = overrun;
        end
        if (act == 1) clr_ovr = 1'b0;
        if (act == 2) po_ready = 1'b0;
        clk_wait(1);
        sclk = 1'b0;
    endtask

    task automatic send_word(input logic [DATA_W-1:0] b, input int nbits, input int act);
        for (int i = DATA_W - 1; i >= DATA_W - nbits; i--)
            send_bit(b[i], (i == DATA_W - nbits) ? act : 0);
        clk_wait(4);
    endtask

    task automatic check_acc(input string tag);
        logic [31:0] obs;
        for (int i = chk_idx; i < exp_q.size(); i++) begin
            obs = (i < acc_q.size()) ? 32'(acc_q[i]) : 32'hDEAD_BEEF;
            chk($sformatf("%s_word%0d", tag, i), obs, 32'(exp_q[i]));
        end
        chk({tag, "_count"}, acc_q.size(), exp_q.size());
        chk_idx = exp_q.size();
    endtask

    task automatic accept_pulse();
        po_ready = 1'b1;
        clk_wait(1);
        po_ready = 1'b0;
        clk_wait(1);
    endtask

    initial begin
        int                v0;
        int                f0;
        logic [DATA_W-1:0] rb;

        rst_L    = 1'b0;
        sclk     = 1'b0;
        mosi     = 1'b0;
        cs_L     = 1'b1;
        po_ready = 1'b0;
        clr_ovr  = 1'b0;
        #23;
        chk("rst_po", po, 0);
        chk("rst_po_valid", po_valid, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_busy", busy, 0);
        clk_wait(1);
        rst_L = 1'b1;
        clk_wait(3);

        // Single byte 0xA5 with consumer always ready.
        po_ready = 1'b1;
        v0 = vcyc;
        f0 = fecyc;
        cs_L = 1'b0;
        clk_wait(1);
        chk("busy_latency_lo", busy, 0);
        clk_wait(1);
        chk("busy_on", busy, 1);
        clk_wait(2);
        send_word(8'hA5, 8, 0);
        exp_q.push_back(8'hA5);
        check_acc("single");
        chk("single_valid_cycles", vcyc - v0, 1);
        chk("single_overrun", overrun, 0);
        cs_L = 1'b1;
        clk_wait(1);
        chk("busy_latency_hi", busy, 1);
        clk_wait(1);
        chk("busy_off", busy, 0);
        clk_wait(4);
        chk("single_no_frame_err", fecyc - f0, 0);

        // Back-to-back fixed and random words in one frame.
        cs_L = 1'b0;
        clk_wait(4);
        foreach (exp_q[i]) ;
        send_word(8'h3C, 8, 0); exp_q.push_back(8'h3C);
        send_word(8'hC3, 8, 0); exp_q.push_back(8'hC3);
        send_word(8'hFF, 8, 0); exp_q.push_back(8'hFF);
        send_word(8'h00, 8, 0); exp_q.push_back(8'h00);
        for (int k = 0; k < 6; k++) begin
            rb = DATA_W'($urandom_range(0, 255));
            send_word(rb, 8, 0);
            exp_q.push_back(rb);
        end
        check_acc("b2b");
        chk("b2b_overrun", overrun, 0);

        // Overrun: 0x11 held, 0x22 dropped.
        po_ready = 1'b0;
        send_word(8'h11, 8, 0);
        send_word(8'h22, 8, 0);
        chk("ovr_po_held", po, 8'h11);
        chk("ovr_po_valid", po_valid, 1);
        chk("ovr_flag", overrun, 1);
        accept_pulse();
        exp_q.push_back(8'h11);
        check_acc("ovr_accept");
        chk("ovr_valid_cleared", po_valid, 0);
        clr_ovr = 1'b1;
        clk_wait(1);
        clr_ovr = 1'b0;
        chk("ovr_cleared", overrun, 0);

        // clr_ovr on the same edge a new overrun happens: set wins.
        send_word(8'h33, 8, 0);
        send_word(8'h44, 8, 1);
        chk("ovr_set_wins_edge", snap_ovr, 1);
        chk("ovr_set_wins_after", overrun, 1);
        chk("ovr_set_wins_po", po, 8'h33);
        accept_pulse();
        exp_q.push_back(8'h33);
        clr_ovr = 1'b1;
        clk_wait(1);
        clr_ovr = 1'b0;

        // Consumer accepts on the exact edge the next word completes.
        send_word(8'h55, 8, 0);
        send_word(8'h66, 8, 2);
        exp_q.push_back(8'h55);
        chk("acc_on_done_po", snap_po, 8'h66);
        chk("acc_on_done_valid", snap_pv, 1);
        chk("acc_on_done_ovr", snap_ovr, 0);
        accept_pulse();
        exp_q.push_back(8'h66);
        check_acc("acc_on_done");

        // Framing error after 5 bits, then a clean 0x81.
        po_ready = 1'b1;
        f0 = fecyc;
        send_word(8'hB8, 5, 0);
        cs_L = 1'b1;
        clk_wait(6);
        chk("frame_err_pulse", fecyc - f0, 1);
        chk("frame_err_no_word", acc_q.size(), exp_q.size());
        cs_L = 1'b0;
        clk_wait(4);
        f0 = fecyc;
        send_word(8'h81, 8, 0);
        exp_q.push_back(8'h81);
        cs_L = 1'b1;
        clk_wait(6);
        check_acc("after_frame_err");
        chk("full_byte_no_frame_err", fecyc - f0, 0);

        // Reset mid-word with a pending word and a sticky overrun.
        po_ready = 1'b0;
        cs_L = 1'b0;
        clk_wait(4);
        send_word(8'h5A, 8, 0);
        send_word(8'h5B, 8, 0);
        send_word(8'hE0, 3, 0);
        chk("pre_rst_valid", po_valid, 1);
        chk("pre_rst_ovr", overrun, 1);
        #3;
        rst_L = 1'b0;
        #1;
        chk("mid_rst_po", po, 0);
        chk("mid_rst_po_valid", po_valid, 0);
        chk("mid_rst_overrun", overrun, 0);
        chk("mid_rst_frame_err", frame_err, 0);
        chk("mid_rst_busy", busy, 0);
        cs_L = 1'b1;
        clk_wait(3);
        rst_L = 1'b1;
        clk_wait(3);
        po_ready = 1'b1;
        f0 = fecyc;
        cs_L = 1'b0;
        clk_wait(4);
        rb = DATA_W'($urandom_range(0, 255));
        send_word(8'h7E, 8, 0);
        exp_q.push_back(8'h7E);
        send_word(rb, 8, 0);
        exp_q.push_back(rb);
        cs_L = 1'b1;
        clk_wait(6);
        check_acc("post_rst");
        chk("post_rst_no_frame_err", fecyc - f0, 0);
        chk("post_rst_overrun", overrun, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
